// File: rtl/stream_order_check.sv
// Framed-stream ordering monitor: checks adjacent beats against a selectable
// strict/non-strict, ascending/descending relation and reports per-frame stats.
module stream_order_check #(
  parameter int K    = 8,
  parameter int CNTW = 16
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic [1:0]      mode,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [K-1:0]    in_data,
  input  logic            in_last,
  output logic            out_valid,
  input  logic            out_ready,
  output logic            out_ordered,
  output logic [CNTW-1:0] out_viol_cnt,
  output logic [CNTW-1:0] out_len,
  output logic [K-1:0]    out_max,
  output logic [K-1:0]    out_min
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_RUN,
    S_REPORT
  } state_t;

  state_t          r_state;
  state_t          w_state_next;
  logic [1:0]      r_mode_q;
  logic [K-1:0]    r_prev;
  logic [K-1:0]    r_max;
  logic [K-1:0]    r_min;
  logic [CNTW-1:0] r_len;
  logic [CNTW-1:0] r_viol;
  logic            r_ordered;

  logic            w_beat;
  logic [K-1:0]    w_lhs;
  logic [K-1:0]    w_rhs;
  logic            w_pass;
  logic [CNTW-1:0] w_len_next;
  logic [CNTW-1:0] w_viol_next;

  assign in_ready = (r_state != S_REPORT);
  assign w_beat   = in_valid & in_ready;

  // Ascending modes reuse the descending "lhs > rhs" test with operands swapped.
  assign w_lhs  = r_mode_q[1] ? in_data : r_prev;
  assign w_rhs  = r_mode_q[1] ? r_prev  : in_data;
  assign w_pass = (w_lhs > w_rhs) | (r_mode_q[0] & (w_lhs == w_rhs));

  assign w_len_next  = (r_len == '1) ? r_len : r_len + 1'b1;
  assign w_viol_next = (!w_pass && (r_viol != '1)) ? r_viol + 1'b1 : r_viol;

  // NOTE: every always_comb output gets a default first so no path can infer a latch.
  always_comb begin
    w_state_next = r_state;
    case (r_state)
      S_IDLE:   if (w_beat) w_state_next = in_last ? S_REPORT : S_RUN;
      S_RUN:    if (w_beat && in_last) w_state_next = S_REPORT;
      S_REPORT: if (out_ready) w_state_next = S_IDLE;
      default:  w_state_next = S_IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= S_IDLE;
    else        r_state <= w_state_next;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_mode_q  <= '0;
      r_prev    <= '0;
      r_max     <= '0;
      r_min     <= '0;
      r_len     <= '0;
      r_viol    <= '0;
      r_ordered <= 1'b0;
    end else if (w_beat) begin
      r_prev <= in_data;
      if (r_state == S_IDLE) begin
        r_mode_q <= mode;
        r_max    <= in_data;
        r_min    <= in_data;
        r_len    <= CNTW'(1);
        r_viol   <= '0;
        if (in_last) r_ordered <= 1'b1;
      end else begin
        r_len  <= w_len_next;
        r_viol <= w_viol_next;
        if (in_data > r_max) r_max <= in_data;
        if (in_data < r_min) r_min <= in_data;
        if (in_last) r_ordered <= (w_viol_next == '0);
      end
    end
  end

  // Accumulators double as report outputs: no beat is accepted while REPORT holds them.
  assign out_valid    = (r_state == S_REPORT);
  assign out_ordered  = r_ordered;
  assign out_viol_cnt = r_viol;
  assign out_len      = r_len;
  assign out_max      = r_max;
  assign out_min      = r_min;

endmodule

// File: doc/stream_order_check.md
Name: stream_order_check

Overview:
- Sequential, parametrised successor to the fixed three-operand chained magnitude comparators.
- Accepts an arbitrary-length framed stream of unsigned K-bit values over a valid/ready handshake.
- Checks the frame against a selectable ordering mode: strict or non-strict, descending or ascending.
- At frame end, reports an ordered flag, violation count, frame length, max and min; used as a datapath monitor/checker.

Parameters:
- K, 8, data width in bits; values are unsigned.
- CNTW, 16, width of the length and violation counters; both saturate.

Ports:
- clk  input  1  system clock, rising edge.
- rst_n  input  1  asynchronous active-low reset.
- mode  input  2  ordering mode; 00 strict desc (prev>cur), 01 non-strict desc (prev>=cur), 10 strict asc (prev<cur), 11 non-strict asc (prev<=cur).
- in_valid  input  1  input beat valid.
- in_ready  output  1  block can accept a beat.
- in_data  input  K  input value.
- in_last  input  1  marks the final beat of a frame.
- out_valid  output  1  frame report valid.
- out_ready  input  1  report consumer ready.
- out_ordered  output  1  1 if zero violations in the frame.
- out_viol_cnt  output  CNTW  number of adjacent pairs failing the mode relation.
- out_len  output  CNTW  number of beats in the frame.
- out_max  output  K  largest value in the frame.
- out_min  output  K  smallest value in the frame.

Behaviour:
- Beat transfer: in_valid & in_ready at a rising clk. Report transfer: out_valid & out_ready.
- States: IDLE (await first beat), RUN (frame open), REPORT (result held).
- in_ready = (state != REPORT); it is combinational from the state register only, with no dependency on in_valid.
- Reset (rst_n low, asynchronous):
  - state = IDLE.
  - out_valid, out_ordered, out_viol_cnt, out_len, out_max, out_min, and the internal prev/mode_q registers = 0.
  - in_ready therefore reads 1.
- IDLE, on beat:
  - Latch mode into mode_q; mode is ignored for the rest of the frame.
  - prev = max = min = in_data; len = 1; viol = 0.
  - If in_last: go to REPORT; else go to RUN.
- RUN, on beat:
  - Evaluate the relation(prev, in_data) selected by mode_q. If it fails, viol += 1, saturating at 2^CNTW-1.
  - len += 1, saturating. Update max/min with unsigned compare (ties keep the stored value). prev = in_data.
  - If in_last: go to REPORT.
- Comparison is unsigned, MSB-first: gt = first differing bit has prev=1; eq = all bits equal.
  - Strict desc = gt; non-strict = gt|eq; ascending modes swap the operands.
- REPORT entry (the cycle after the last-beat transfer):
  - out_valid = 1; outputs reflect the full frame including the last beat.
  - out_ordered = (viol == 0).
  - Latency from last-beat handshake to out_valid is 1 cycle.
- REPORT hold: all out_* are stable while out_valid & !out_ready.
- On report transfer: out_valid = 0, state = IDLE. Data outputs keep their last values (don't care while out_valid = 0).
  - The next frame's first beat can be accepted the cycle after the report handshake. No overlap, because in_ready = 0 in REPORT.
- Single-beat frame: out_len = 1, viol = 0, ordered = 1, max = min = data.
- Equal neighbours: violation in strict modes, pass in non-strict modes.
- in_valid = 0 gaps inside a frame are allowed; state and counters hold.
- Reset mid-frame or during REPORT: immediate return to reset values. The partial frame is discarded and no report is produced.

Test Plan:
- mode=00, K=8, frame 9,5,2(last) -> one cycle later: out_valid=1, ordered=1, viol=0, len=3, max=9, min=2.
- mode=00, frame 5,5,3(last) -> ordered=0, viol=1, len=3. Same frame with mode=01 -> ordered=1, viol=0.
- mode=10, frame 1,4,2,7,7(last) with in_valid gaps between beats -> viol=2 (4>2, 7=7), len=5, max=7, min=1.
- Single beat 0xFF with last, mode=11 -> len=1, ordered=1, max=min=0xFF. Change mode mid-frame on another frame -> result follows the first-beat mode.
- Hold out_ready=0 for 5 cycles in REPORT while driving in_valid=1 -> in_ready=0, outputs stable, no beats consumed. Release -> next frame starts the following cycle.
- Pulse rst_n low mid-frame after 3 beats -> all outputs 0 immediately, in_ready=1. A fresh frame 3,2(last) then reports len=2, viol=0.
- CNTW=4, 20-beat non-strict-asc-violating descending frame under mode=11 -> viol=15, len=15 (saturated).
